// File: rtl/rr_arbiter_8.sv
// Eight-requester round-robin arbiter with a registered binary grant index.
// Define ARB_TIMEOUT_EN to add forced release after TIMEOUT cycles and the timeout pulse output.
module rr_arbiter_8 #(
  parameter int TIMEOUT = 16,
  parameter int CW      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid
`ifdef ARB_TIMEOUT_EN
  ,
  output logic       timeout
`endif
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  // Reject configurations the timeout counter cannot represent.
  if (TIMEOUT < 2 || TIMEOUT > 255 || TIMEOUT > (2 ** CW) - 1) begin : g_bad_param
    $error("rr_arbiter_8: TIMEOUT out of range for CW");
  end

  logic [0:0] state;
  logic [2:0] ptr;
  logic [2:0] pick;
  logic [2:0] cand;

`ifdef ARB_TIMEOUT_EN
  logic [CW-1:0] cnt;
`endif

  // Search from ptr upward with wrap; walking offsets high-to-low lets the
  // lowest offset that requests overwrite the rest.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    pick = ptr;
    cand = ptr;
    for (int k = 7; k >= 0; k--) begin
      cand = ptr + 3'(k);
      if (req[cand]) pick = cand;
    end
  end

  // NOTE: registered state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 3'd0;
      gnt_idx   <= 3'd0;
      gnt_valid <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt       <= '0;
      timeout   <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      timeout <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (|req) begin
            gnt_idx   <= pick;
            gnt_valid <= 1'b1;
            state     <= GRANT;
`ifdef ARB_TIMEOUT_EN
            cnt       <= '0;
`endif
          end
        end
        GRANT: begin
          // done takes precedence over a coincident forced release.
          if (done) begin
            gnt_valid <= 1'b0;
            ptr       <= gnt_idx + 3'd1;
            state     <= IDLE;
          end
`ifdef ARB_TIMEOUT_EN
          else if (cnt == CW'(TIMEOUT - 1)) begin
            gnt_valid <= 1'b0;
            ptr       <= gnt_idx + 3'd1;
            state     <= IDLE;
            timeout   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Self-checking bench for rr_arbiter_8: directed vectors plus a cycle-level reference model.
// Build with ARB_TIMEOUT_EN defined to also exercise the forced-release path (TIMEOUT=4).
module tb_rr_arbiter_8;

`ifdef ARB_TIMEOUT_EN
  localparam int TB_TIMEOUT = 4;
  localparam int HOLD_N     = 2;
`else
  localparam int TB_TIMEOUT = 16;
  localparam int HOLD_N     = 5;
`endif

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req   = 8'h00;
  logic       done  = 1'b0;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
`ifdef ARB_TIMEOUT_EN
  logic       timeout;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  rr_arbiter_8 #(.TIMEOUT(TB_TIMEOUT), .CW(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
`ifdef ARB_TIMEOUT_EN
    ,
    .timeout   (timeout)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the first requester at or after the pointer wins;
  // the pointer moves just past whoever was last released.
  function automatic int rr_pick(input logic [7:0] r, input int p);
    for (int k = 0; k < 8; k++)
      if (r[(p + k) % 8]) return (p + k) % 8;
    return 0;
  endfunction

  logic m_valid;
  int   m_idx;
  int   m_ptr;
  int   m_held;
  logic m_to;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_idx   <= 0;
      m_ptr   <= 0;
      m_held  <= 0;
      m_to    <= 1'b0;
    end else begin
      m_to <= 1'b0;
      if (!m_valid) begin
        if (req != 8'h00) begin
          m_idx   <= rr_pick(req, m_ptr);
          m_valid <= 1'b1;
          m_held  <= 1;
        end
      end else if (done) begin
        m_valid <= 1'b0;
        m_ptr   <= (m_idx + 1) % 8;
`ifdef ARB_TIMEOUT_EN
      end else if (m_held == TB_TIMEOUT) begin
        m_valid <= 1'b0;
        m_ptr   <= (m_idx + 1) % 8;
        m_to    <= 1'b1;
`endif
      end else begin
        m_held <= m_held + 1;
      end
    end
  end

  always @(negedge clk) begin
    check("cmp_valid", int'(gnt_valid), int'(m_valid));
    check("cmp_idx", int'(gnt_idx), m_idx);
`ifdef ARB_TIMEOUT_EN
    check("cmp_timeout", int'(timeout), int'(m_to));
`endif
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_grant(input string name, input int exp);
    step();
    check({name, "_valid"}, int'(gnt_valid), 1);
    check({name, "_idx"}, int'(gnt_idx), exp);
  endtask

  task automatic release_grant(input logic [7:0] next_req);
    done = 1'b1;
    req  = next_req;
    step();
    done = 1'b0;
    check("bubble_valid", int'(gnt_valid), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 8'hFF;
    done  = 1'b0;
    repeat (3) begin
      step();
      check("reset_valid", int'(gnt_valid), 0);
      check("reset_idx", int'(gnt_idx), 0);
    end
    rst_n = 1'b1;
    expect_grant("reset_first", 0);

    for (int k = 1; k <= 8; k++) begin
      release_grant(8'hFF);
      expect_grant("rotation", k % 8);
    end

    release_grant(8'h10);
    expect_grant("sparse_pre", 4);
    release_grant(8'h03);
    expect_grant("sparse_wrap", 0);
    release_grant(8'h03);
    expect_grant("sparse_next", 1);

    release_grant(8'h04);
    expect_grant("hold_start", 2);
    req = 8'h00;
    for (int k = 0; k < HOLD_N; k++) begin
      step();
      check("hold_valid", int'(gnt_valid), 1);
      check("hold_idx", int'(gnt_idx), 2);
    end
    release_grant(8'h00);
    step();
    check("idle_no_req", int'(gnt_valid), 0);

    req = 8'h40;
    expect_grant("pre_reset", 6);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_valid", int'(gnt_valid), 0);
    check("async_reset_idx", int'(gnt_idx), 0);
    step();
    rst_n = 1'b1;
    expect_grant("post_reset", 6);

`ifdef ARB_TIMEOUT_EN
    begin
      int held;
      release_grant(8'h08);
      expect_grant("to_start", 3);
      req  = 8'hFF;
      held = 1;
      for (int k = 0; k < 20; k++) begin
        step();
        if (!gnt_valid) break;
        held++;
      end
      check("to_held_cycles", held, TB_TIMEOUT);
      check("to_pulse", int'(timeout), 1);
      expect_grant("to_next", 4);
      check("to_pulse_end", int'(timeout), 0);
    end
`endif

    release_grant(8'h00);
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
